// File: rtl/debounce_multi.sv
// Multi-channel push-button debouncer: each channel is synchronised, debounced
// by its own counter, and produces a stable level plus registered event pulses.
module debounce_multi #(
  parameter int NUM_BTNS                 = 4,
  parameter int SYNC_STAGES              = 2,
  parameter int DEBOUNCE_COUNT_THRESHOLD = 100,
  parameter int LONG_PRESS_THRESHOLD     = 5000
) (
  input  logic                sysclk,
  input  logic                reset_n,
  input  logic [NUM_BTNS-1:0] btn,
  output logic [NUM_BTNS-1:0] btn_state,
  output logic [NUM_BTNS-1:0] btn_pressed,
  output logic [NUM_BTNS-1:0] btn_released,
  output logic [NUM_BTNS-1:0] btn_long_pressed
);

  localparam int DW = $clog2(DEBOUNCE_COUNT_THRESHOLD + 1);
  localparam int HW = $clog2(LONG_PRESS_THRESHOLD + 1);

  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_COUNT_THRESHOLD - 1);
  localparam logic [HW-1:0] H_MAX  = HW'(LONG_PRESS_THRESHOLD);
  localparam logic [HW-1:0] H_LAST = HW'(LONG_PRESS_THRESHOLD - 1);

  if (NUM_BTNS < 1) begin : g_bad_num_btns
    $error("debounce_multi: NUM_BTNS must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("debounce_multi: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_COUNT_THRESHOLD < 1) begin : g_bad_debounce
    $error("debounce_multi: DEBOUNCE_COUNT_THRESHOLD must be >= 1");
  end
  if (LONG_PRESS_THRESHOLD < 1) begin : g_bad_long_press
    $error("debounce_multi: LONG_PRESS_THRESHOLD must be >= 1");
  end

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [DW-1:0]          dcnt;
    logic [HW-1:0]          hcnt;
    logic                   state_q;
    logic                   press_q;
    logic                   rel_q;
    logic                   long_q;
    logic                   s;
    logic                   accept;

    assign s      = sync_q[SYNC_STAGES-1];
    assign accept = (s != state_q) && (dcnt == D_LAST);

    always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
        sync_q  <= '0;
        dcnt    <= '0;
        hcnt    <= '0;
        state_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        long_q  <= 1'b0;
      end else begin
        sync_q  <= {sync_q[SYNC_STAGES-2:0], btn[i]};
        press_q <= accept & ~state_q;
        rel_q   <= accept & state_q;
        long_q  <= 1'b0;

        if (s == state_q) begin
          dcnt <= '0;
        end else if (dcnt == D_LAST) begin
          dcnt    <= '0;
          state_q <= ~state_q;
        end else begin
          dcnt <= dcnt + 1'b1;
        end

        // Clearing on any accept edge lets a release beat a same-cycle long pulse.
        if (!state_q || accept) begin
          hcnt <= '0;
        end else if (hcnt != H_MAX) begin
          hcnt   <= hcnt + 1'b1;
          long_q <= (hcnt == H_LAST);
        end
      end
    end

    assign btn_state[i]        = state_q;
    assign btn_pressed[i]      = press_q;
    assign btn_released[i]     = rel_q;
    assign btn_long_pressed[i] = long_q;
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench for debounce_multi: directed stimulus pushes hand-computed
// pulse events; a negedge monitor pops and compares whenever a pulse appears.
module tb_debounce_multi;

  localparam int DLY = 102;  // SYNC_STAGES + DEBOUNCE_COUNT_THRESHOLD

  logic       sysclk = 1'b0;
  logic       reset_n;
  logic [3:0] btn;
  logic [3:0] btn_state;
  logic [3:0] btn_pressed;
  logic [3:0] btn_released;
  logic [3:0] btn_long_pressed;

  debounce_multi #(
    .NUM_BTNS(4),
    .SYNC_STAGES(2),
    .DEBOUNCE_COUNT_THRESHOLD(100),
    .LONG_PRESS_THRESHOLD(500)
  ) dut (
    .sysclk(sysclk),
    .reset_n(reset_n),
    .btn(btn),
    .btn_state(btn_state),
    .btn_pressed(btn_pressed),
    .btn_released(btn_released),
    .btn_long_pressed(btn_long_pressed)
  );

  always #10 sysclk = ~sysclk;

  int unsigned cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  typedef struct {
    int unsigned tag;
    logic [3:0]  pr;
    logic [3:0]  rl;
    logic [3:0]  lg;
    logic [3:0]  st;
    int unsigned at;
  } exp_t;

  exp_t        sb[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic push(input int unsigned tag, input logic [3:0] pr, input logic [3:0] rl,
                      input logic [3:0] lg, input logic [3:0] st, input int unsigned at);
    exp_t e;
    e.tag = tag; e.pr = pr; e.rl = rl; e.lg = lg; e.st = st; e.at = at;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic wait_cycles(input int unsigned n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  // Monitor: every pulse must match the head of the scoreboard on the exact cycle.
  always @(negedge sysclk) begin
    exp_t e;
    if ((btn_pressed | btn_released | btn_long_pressed) != 4'h0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d pr=%h rl=%h lg=%h st=%h required no pulse",
                 cyc, btn_pressed, btn_released, btn_long_pressed, btn_state);
      end else begin
        e = sb.pop_front();
        if (btn_pressed !== e.pr || btn_released !== e.rl || btn_long_pressed !== e.lg ||
            btn_state !== e.st || cyc != e.at) begin
          errors++;
          $display("FAIL event_t%0d: got cyc=%0d pr=%h rl=%h lg=%h st=%h required cyc=%0d pr=%h rl=%h lg=%h st=%h",
                   e.tag, cyc, btn_pressed, btn_released, btn_long_pressed, btn_state,
                   e.at, e.pr, e.rl, e.lg, e.st);
        end
      end
    end else if (sb.size() != 0 && sb[0].at < cyc) begin
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_t%0d: got no pulse by cyc=%0d required pr=%h rl=%h lg=%h at cyc=%0d",
               e.tag, cyc, e.pr, e.rl, e.lg, e.at);
    end
  end

  initial begin
    #(400000 * 20);
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned c;
    reset_n = 1'b0;
    btn     = 4'h0;

    // 1: reset, all outputs quiet
    repeat (4) begin
      @(negedge sysclk);
      chk("reset_state", {28'h0, btn_state}, 32'h0);
      chk("reset_pulses", {20'h0, btn_pressed, btn_released, btn_long_pressed}, 32'h0);
    end
    @(posedge sysclk); #1;
    reset_n = 1'b1;
    wait_cycles(5);

    // 2: bouncing press on channel 0, then clean hold and release
    btn[0] = 1'b1; #7;  btn[0] = 1'b0; #10;
    btn[0] = 1'b1; #15; btn[0] = 1'b0; #10;
    btn[0] = 1'b1; #27; btn[0] = 1'b0;
    @(posedge sysclk); #1;
    btn[0] = 1'b1; c = cyc;
    push(2, 4'b0001, 4'b0000, 4'b0000, 4'b0001, c + DLY);
    wait_cycles(300);
    btn[0] = 1'b0; c = cyc;
    push(2, 4'b0000, 4'b0001, 4'b0000, 4'b0000, c + DLY);
    wait_cycles(300);

    // 3: two 1000-cycle holds on channel 1, one long pulse each
    repeat (2) begin
      btn[1] = 1'b1; c = cyc;
      push(3, 4'b0010, 4'b0000, 4'b0000, 4'b0010, c + DLY);
      push(3, 4'b0000, 4'b0000, 4'b0010, 4'b0010, c + DLY + 500);
      wait_cycles(1000);
      btn[1] = 1'b0; c = cyc;
      push(3, 4'b0000, 4'b0010, 4'b0000, 4'b0000, c + DLY);
      wait_cycles(300);
    end

    // 4: 99-cycle glitch is rejected, 100-cycle hold is accepted
    btn[2] = 1'b1;
    wait_cycles(99);
    btn[2] = 1'b0;
    wait_cycles(300);
    chk("glitch99_state", {28'h0, btn_state}, 32'h0);
    btn[2] = 1'b1; c = cyc;
    wait_cycles(100);
    btn[2] = 1'b0;
    push(4, 4'b0100, 4'b0000, 4'b0000, 4'b0100, c + DLY);
    push(4, 4'b0000, 4'b0100, 4'b0000, 4'b0000, c + 100 + DLY);
    wait_cycles(300);

    // 5: simultaneous press on all channels, staggered release
    btn = 4'hF; c = cyc;
    push(5, 4'hF, 4'h0, 4'h0, 4'hF, c + DLY);
    wait_cycles(200);
    btn = 4'b1110; c = cyc;
    push(5, 4'h0, 4'b0001, 4'h0, 4'b1110, c + DLY);
    wait_cycles(10);
    btn = 4'b1100; c = cyc;
    push(5, 4'h0, 4'b0010, 4'h0, 4'b1100, c + DLY);
    wait_cycles(10);
    btn = 4'b1000; c = cyc;
    push(5, 4'h0, 4'b0100, 4'h0, 4'b1000, c + DLY);
    wait_cycles(10);
    btn = 4'b0000; c = cyc;
    push(5, 4'h0, 4'b1000, 4'h0, 4'b0000, c + DLY);
    wait_cycles(300);

    // 6: reset mid-hold on channel 3 drops state silently, then re-presses
    btn[3] = 1'b1; c = cyc;
    push(6, 4'b1000, 4'b0000, 4'b0000, 4'b1000, c + DLY);
    wait_cycles(150);
    chk("hold_before_reset", {28'h0, btn_state}, 32'h8);
    reset_n = 1'b0;
    repeat (3) begin
      @(negedge sysclk);
      chk("midreset_state", {28'h0, btn_state}, 32'h0);
    end
    @(posedge sysclk); #1;
    reset_n = 1'b1; c = cyc;
    push(6, 4'b1000, 4'b0000, 4'b0000, 4'b1000, c + DLY);
    wait_cycles(200);
    btn[3] = 1'b0; c = cyc;
    push(6, 4'b0000, 4'b1000, 4'b0000, 4'b0000, c + DLY);
    wait_cycles(300);

    chk("scoreboard_drained", sb.size(), 32'h0);
    chk("final_state", {28'h0, btn_state}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
